// File: rtl/fpga_config_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpga_config_loader_pkg
//  Purpose  : Shared constants for the serial FPGA configuration loader:
//             frame marker, payload field widths/offsets, CRC polynomial,
//             FSM state encoding and the serial CRC-8 step function.
//  Revision : 1.0 - initial release
// ============================================================================
package fpga_config_loader_pkg;

    // Frame marker and payload field widths
    localparam logic [15:0] C_SYNC_WORD = 16'hB5A3;
    localparam int          C_BRB_W     = 900;
    localparam int          C_BSB_W     = 1728;
    localparam int          C_LB_W      = 80;
    localparam int          C_IO_W      = 30;
    localparam int          C_CFG_BITS  = C_BRB_W + C_BSB_W + C_LB_W + 4 * C_IO_W;

    // Field offsets inside the shadow/active vector (bottom IO sits at bit 0)
    localparam int C_BOT_OFS   = 0;
    localparam int C_TOP_OFS   = C_BOT_OFS   + C_IO_W;
    localparam int C_RIGHT_OFS = C_TOP_OFS   + C_IO_W;
    localparam int C_LEFT_OFS  = C_RIGHT_OFS + C_IO_W;
    localparam int C_LB_OFS    = C_LEFT_OFS  + C_IO_W;
    localparam int C_BSB_OFS   = C_LB_OFS    + C_LB_W;
    localparam int C_BRB_OFS   = C_BSB_OFS   + C_BSB_W;

    // Bit counter width (covers the longest field, the payload)
    localparam int C_CNT_W = 12;

    // CRC-8 generator polynomial x^8 + x^2 + x + 1
    localparam logic [7:0] C_CRC_POLY = 8'h07;

    // FSM state encoding
    localparam int                C_ST_W      = 3;
    localparam logic [C_ST_W-1:0] C_ST_IDLE   = 3'd0;
    localparam logic [C_ST_W-1:0] C_ST_LEN    = 3'd1;
    localparam logic [C_ST_W-1:0] C_ST_DATA   = 3'd2;
    localparam logic [C_ST_W-1:0] C_ST_CRC    = 3'd3;
    localparam logic [C_ST_W-1:0] C_ST_COMMIT = 3'd4;

    // One serial CRC-8 step: MSB-out feedback, polynomial XORed on a 1
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? C_CRC_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_config_loader_crc8.sv
`default_nettype none
// ============================================================================
//  Module   : cfg_crc8_serial
//  Purpose  : Bit-serial CRC-8 (poly 0x07, init 0x00). Clear has priority
//             over enable; one payload bit is absorbed per enabled cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module cfg_crc8_serial
    import fpga_config_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_bit_in,
    output logic [7:0] o_crc_out
);

    logic [7:0] r_crc;

    // CRC register: cleared between frames, advanced on each payload bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= 8'h00;
        end else if (i_clear) begin
            r_crc <= 8'h00;
        end else if (i_enable) begin
            r_crc <= crc8_step(r_crc, i_bit_in);
        end
    end

    assign o_crc_out = r_crc;

endmodule
`default_nettype wire

// File: rtl/fpga_config_loader.sv
`default_nettype none
// ============================================================================
//  Module   : fpga_config_loader
//  Purpose  : Receives a serial configuration frame (sync, length, payload,
//             CRC-8), assembles the payload in a shadow register and copies
//             it to the active select outputs only when the CRC matches.
//  Revision : 1.0 - initial release
// ============================================================================
module fpga_config_loader
    import fpga_config_loader_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD = C_SYNC_WORD,
    parameter int          CFG_BITS  = C_CFG_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [C_BRB_W-1:0]  brbselect,
    output logic [C_BSB_W-1:0]  bsbselect,
    output logic [C_LB_W-1:0]   lbselect,
    output logic [C_IO_W-1:0]   leftioselect,
    output logic [C_IO_W-1:0]   rightioselect,
    output logic [C_IO_W-1:0]   topioselect,
    output logic [C_IO_W-1:0]   bottomioselect,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_error
);

    logic [C_ST_W-1:0]  r_state;
    logic [C_ST_W-1:0]  w_state_next;
    logic [15:0]        r_window;
    logic [14:0]        r_shift;       // length / received-CRC collector
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] w_cnt_next;
    logic [CFG_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0] r_active;
    logic               r_ready;
    logic               r_done;
    logic               r_error;
    logic               w_accept;
    logic               w_err_set;
    logic               w_commit;
    logic               w_crc_clear;
    logic               w_crc_en;
    logic [15:0]        w_window_shift;
    logic [15:0]        w_len_word;
    logic [7:0]         w_crc_word;
    logic [7:0]         w_crc_calc;

    assign w_accept       = cfg_valid & r_ready;
    assign w_window_shift = {r_window[14:0], cfg_data};
    assign w_len_word     = {r_shift, cfg_data};
    assign w_crc_word     = {r_shift[6:0], cfg_data};

    cfg_crc8_serial u_crc (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_crc_clear),
        .i_enable  (w_crc_en),
        .i_bit_in  (cfg_data),
        .o_crc_out (w_crc_calc)
    );

    // Next-state, bit counter and per-cycle control strobes
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_err_set    = 1'b0;
        w_commit     = 1'b0;
        w_crc_clear  = 1'b0;
        w_crc_en     = 1'b0;
        case (r_state)
            C_ST_IDLE: begin
                w_crc_clear = 1'b1;
                w_cnt_next  = '0;
                if (w_accept && (w_window_shift == SYNC_WORD)) begin
                    w_state_next = C_ST_LEN;
                end
            end
            C_ST_LEN: begin
                if (w_accept) begin
                    if (r_cnt == C_CNT_W'(15)) begin
                        w_cnt_next = '0;
                        if (w_len_word == 16'(CFG_BITS)) begin
                            w_state_next = C_ST_DATA;
                        end else begin
                            w_err_set    = 1'b1;
                            w_state_next = C_ST_IDLE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            C_ST_DATA: begin
                if (w_accept) begin
                    w_crc_en = 1'b1;
                    if (r_cnt == C_CNT_W'(CFG_BITS - 1)) begin
                        w_cnt_next   = '0;
                        w_state_next = C_ST_CRC;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            C_ST_CRC: begin
                if (w_accept) begin
                    if (r_cnt == C_CNT_W'(7)) begin
                        w_cnt_next = '0;
                        if (w_crc_word == w_crc_calc) begin
                            w_state_next = C_ST_COMMIT;
                        end else begin
                            w_err_set    = 1'b1;
                            w_state_next = C_ST_IDLE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
            end
            C_ST_COMMIT: begin
                w_commit     = 1'b1;
                w_state_next = C_ST_IDLE;
            end
            default: begin
                w_state_next = C_ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // State, counter, sync window and header/CRC shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= C_ST_IDLE;
            r_cnt    <= '0;
            r_window <= '0;
            r_shift  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            // Window only lives while staying in IDLE, so it is empty on re-entry
            if ((r_state != C_ST_IDLE) || (w_state_next != C_ST_IDLE)) begin
                r_window <= '0;
            end else if (w_accept) begin
                r_window <= w_window_shift;
            end
            if (w_accept && ((r_state == C_ST_LEN) || (r_state == C_ST_CRC))) begin
                r_shift <= w_len_word[14:0];
            end
        end
    end

    // Shadow register: payload bits enter at the LSB, first bit ends at the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (w_accept && (r_state == C_ST_DATA)) begin
            r_shadow <= {r_shadow[CFG_BITS-2:0], cfg_data};
        end
    end

    // Active outputs and status flags: only a commit may touch the selects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_active <= r_shadow;
                r_error  <= 1'b0;
            end else if (w_err_set) begin
                r_error <= 1'b1;
            end
        end
    end

    // Ready is low during reset and for the single COMMIT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_state_next != C_ST_COMMIT);
        end
    end

    assign cfg_ready      = r_ready;
    assign cfg_busy       = (r_state != C_ST_IDLE);
    assign cfg_done       = r_done;
    assign cfg_error      = r_error;
    assign brbselect      = r_active[C_BRB_OFS   +: C_BRB_W];
    assign bsbselect      = r_active[C_BSB_OFS   +: C_BSB_W];
    assign lbselect       = r_active[C_LB_OFS    +: C_LB_W];
    assign leftioselect   = r_active[C_LEFT_OFS  +: C_IO_W];
    assign rightioselect  = r_active[C_RIGHT_OFS +: C_IO_W];
    assign topioselect    = r_active[C_TOP_OFS   +: C_IO_W];
    assign bottomioselect = r_active[C_BOT_OFS   +: C_IO_W];

endmodule
`default_nettype wire

// File: doc/fpga_config_loader.md
FPGA_CONFIG_LOADER -- requirements
Module: fpga_config_loader

Interface
REQ-001 Parameter SYNC_WORD, 16'hB5A3, frame start marker.
REQ-002 Parameter CFG_BITS, 2828, payload length; equals 900+1728+80+4*30.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cfg_data  input  1  serial bitstream bit, MSB first.
REQ-006 cfg_valid  input  1  cfg_data qualifier; a bit is accepted when cfg_valid and cfg_ready are both high.
REQ-007 cfg_ready  output  1  loader can accept a bit.
REQ-008 brbselect  output  900  active routing-block select vector.
REQ-009 bsbselect  output  1728  active switch-block select vector.
REQ-010 lbselect  output  80  active logic-block select vector.
REQ-011 leftioselect, rightioselect, topioselect, bottomioselect  output  30 each  active IO-block select vectors.
REQ-012 cfg_busy  output  1  high in any state other than IDLE.
REQ-013 cfg_done  output  1  one-cycle pulse when a frame is committed.
REQ-014 cfg_error  output  1  sticky; set on a rejected frame, cleared on the next commit.

Function
REQ-015 Frame format SHALL be: 16-bit SYNC_WORD, 16-bit length, CFG_BITS payload bits, then an 8-bit CRC.
REQ-016 FSM states SHALL be IDLE, LEN, DATA, CRC, COMMIT.
REQ-017 IDLE SHALL shift accepted bits into a 16-bit window and enter LEN in the cycle after the window equals SYNC_WORD.
REQ-018 LEN SHALL collect 16 bits; if the value is not CFG_BITS, the FSM SHALL set cfg_error and return to IDLE; otherwise it SHALL enter DATA.
REQ-019 DATA SHALL shift each accepted bit into a CFG_BITS-wide shadow register from the LSB end, using an 12-bit counter; after bit CFG_BITS-1 it SHALL enter CRC.
REQ-020 The shadow layout SHALL be {brbselect, bsbselect, lbselect, leftioselect, rightioselect, topioselect, bottomioselect}, so the first payload bit lands at brbselect[899] and the last at bottomioselect[0].
REQ-021 CRC: CRC-8, polynomial 0x07, init 0x00, computed serially over payload bits only.
REQ-022 CRC state SHALL collect 8 bits; on a match the FSM SHALL enter COMMIT; on a mismatch it SHALL set cfg_error and return to IDLE with the active outputs unchanged.
REQ-023 COMMIT SHALL copy the shadow register to all active select outputs in one cycle, pulse cfg_done, clear cfg_error, and return to IDLE.
REQ-024 cfg_ready SHALL be high in every state except COMMIT.
REQ-025 Active outputs SHALL change only in COMMIT; a partial or failed frame SHALL never alter them.
REQ-026 Cycles with cfg_valid low SHALL hold all state and counters (gaps of any length).
REQ-027 A SYNC_WORD pattern inside LEN, DATA or CRC SHALL be treated as ordinary data, with no resynchronisation.
REQ-028 The IDLE window SHALL be cleared on entry to IDLE, so trailing frame bits cannot form a false sync.

Reset
REQ-029 Asserting rst SHALL force, without a clock: state IDLE, counters 0, window 0, shadow 0, CRC 0.
REQ-030 During rst, outputs SHALL be: all select outputs 0 (all switches open), cfg_done 0, cfg_error 0, cfg_busy 0, cfg_ready 0.
REQ-031 cfg_ready SHALL rise on the first clk edge after rst deasserts.
REQ-032 rst asserted mid-frame SHALL discard the frame and clear the active outputs to 0.

Structure
REQ-033 A shared package SHALL hold SYNC_WORD, CFG_BITS, the per-field widths and offsets, CRC_POLY, and the state encoding.
REQ-034 One sub-module, cfg_crc8_serial, SHALL provide the bitwise CRC with clear, enable, bit-in and crc-out ports.

Verification
REQ-035 Valid frame with payload all ones and correct CRC -> cfg_done pulses once; every select output is all ones; cfg_error is 0.
REQ-036 Payload with only the first bit set (correct CRC) -> brbselect[899]=1 and all other bits 0; payload with only the last bit set -> bottomioselect[0]=1.
REQ-037 Length field 16'd2827 -> cfg_error=1, no cfg_done, outputs hold their previous frame values, FSM in IDLE.
REQ-038 Correct frame except one flipped CRC bit -> cfg_error=1 and outputs unchanged; a following good frame -> cfg_done and cfg_error cleared.
REQ-039 Good frame with random cfg_valid gaps of 0-20 cycles -> result identical to the gapless case.
REQ-040 rst pulse after 1000 payload bits -> outputs 0 and FSM in IDLE; the next full frame commits correctly.
